// File: rtl/pulse_transmitter_delay_line_if.sv
// Bus bundle for the pulse transmitter delay line: control and data inputs
// driven by the sequencer (master), with the delayed tap and status returned by the line (slave).
interface pulse_transmitter_delay_line_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [SELW-1:0]  delay_sel;
  logic [WIDTH-1:0] sig_in;
  logic [WIDTH-1:0] sig_out;
  logic             valid_out;
  logic             sel_clamped;

  modport master (
    output en, flush, delay_sel, sig_in,
    input  sig_out, valid_out, sel_clamped
  );

  modport slave (
    input  en, flush, delay_sel, sig_in,
    output sig_out, valid_out, sel_clamped
  );
endinterface

// File: rtl/pulse_transmitter_delay_line.sv
// Runtime-programmable 0..DEPTH cycle delay line with stall, flush and a fill-based
// valid flag, used to skew-align pulse transmitter channels.
module pulse_transmitter_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                     clk,
  input logic                     sys_rst_n,
  pulse_transmitter_delay_line_if.slave bus
);
  localparam int              SELW    = $clog2(DEPTH + 1);
  localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [SELW-1:0]  r_fill;

  logic [SELW-1:0]  w_eff;
  logic             w_clamp;
  logic [WIDTH-1:0] w_tap;

  // Flush outranks enable, so a sample presented with flush is never captured.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= RESET_VALUE;
      r_fill <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= RESET_VALUE;
      r_fill <= '0;
    end else if (bus.en) begin
      r_stage[0] <= bus.sig_in;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      if (r_fill != DEPTH_S) r_fill <= r_fill + SELW'(1);
    end
  end

  // When DEPTH fills the whole select range, no select value can exceed it.
  generate
    if (DEPTH == (2 ** SELW) - 1) begin : g_noclamp
      assign w_clamp = 1'b0;
    end else begin : g_clamp
      assign w_clamp = (bus.delay_sel > DEPTH_S);
    end
  endgenerate

  assign w_eff = w_clamp ? DEPTH_S : bus.delay_sel;

  always_comb begin
    w_tap = bus.sig_in;
    for (int k = 1; k <= DEPTH; k++) begin
      if (w_eff == SELW'(k)) w_tap = r_stage[k-1];
    end
  end

  assign bus.sig_out     = w_tap;
  assign bus.valid_out   = (r_fill >= w_eff);
  assign bus.sel_clamped = w_clamp;

endmodule

// File: tb/tb_pulse_transmitter_delay_line.sv
// Directed bench for pulse_transmitter_delay_line: a queue-based history model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_pulse_transmitter_delay_line;
  localparam int         WIDTH = 4;
  localparam int         DEPTH = 8;
  localparam logic [3:0] RV    = 4'hA;

  logic clk;
  logic sys_rst_n;
  int   n_checks;
  int   n_errors;

  pulse_transmitter_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pulse_transmitter_delay_line #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: samples accepted since the last reset/flush, newest first, at most DEPTH kept.
  logic [3:0] hist [$];

  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) hist.delete();
    else if (bus.flush) hist.delete();
    else if (bus.en) begin
      hist.push_front(bus.sig_in);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  end

  function automatic int eff_of(int sel);
    return (sel > DEPTH) ? DEPTH : sel;
  endfunction

  function automatic logic [3:0] model_out();
    int e;
    e = eff_of(int'(bus.delay_sel));
    if (e == 0) return bus.sig_in;
    if (hist.size() >= e) return hist[e-1];
    return RV;
  endfunction

  function automatic logic model_valid();
    return hist.size() >= eff_of(int'(bus.delay_sel));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_sig_out", 32'(bus.sig_out), 32'(model_out()));
    check("model_valid", 32'(bus.valid_out), 32'(model_valid()));
    check("model_clamp", 32'(bus.sel_clamped), 32'(int'(bus.delay_sel) > DEPTH));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    sys_rst_n = 1'b0;
    bus.en = 1'b0;
    bus.flush = 1'b0;
    bus.delay_sel = '0;
    bus.sig_in = '0;
    repeat (2) step();
    sys_rst_n = 1'b1;
    step();

    // Fill with 5s, then assert reset mid-cycle and observe the immediate clear.
    bus.delay_sel = 4'd3;
    bus.en = 1'b1;
    bus.sig_in = 4'd5;
    repeat (4) step();
    check("pre_reset_out", 32'(bus.sig_out), 32'h5);
    check("pre_reset_valid", 32'(bus.valid_out), 32'h1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("reset_async_out", 32'(bus.sig_out), 32'hA);
    check("reset_async_valid", 32'(bus.valid_out), 32'h0);
    step();
    check("reset_held_out", 32'(bus.sig_out), 32'hA);
    sys_rst_n = 1'b1;

    // Latency sweep over every delay with a counting input.
    for (int d = 0; d <= DEPTH; d++) begin
      bus.flush = 1'b1;
      bus.en = 1'b0;
      step();
      bus.flush = 1'b0;
      bus.delay_sel = 4'(d);
      for (int n = 0; n < 12; n++) begin
        bus.sig_in = 4'(n);
        bus.en = 1'b1;
        #1;
        check("sweep_out", 32'(bus.sig_out),
              (d == 0) ? 32'(n) : ((n >= d) ? 32'(n - d) : 32'hA));
        check("sweep_valid", 32'(bus.valid_out), 32'(n >= d));
        step();
      end
    end

    // Stall: delay 4, feed 1..4, stall 5 cycles, resume with 5,6.
    bus.flush = 1'b1;
    bus.en = 1'b0;
    step();
    bus.flush = 1'b0;
    bus.delay_sel = 4'd4;
    for (int v = 1; v <= 4; v++) begin
      bus.sig_in = 4'(v);
      bus.en = 1'b1;
      step();
    end
    check("stall_4th_edge", 32'(bus.sig_out), 32'h1);
    bus.en = 1'b0;
    bus.sig_in = 4'd9;
    repeat (5) begin
      step();
      check("stall_hold_out", 32'(bus.sig_out), 32'h1);
      check("stall_hold_valid", 32'(bus.valid_out), 32'h1);
    end
    bus.sig_in = 4'd5;
    bus.en = 1'b1;
    step();
    check("stall_5th_edge", 32'(bus.sig_out), 32'h2);
    bus.sig_in = 4'd6;
    step();
    check("stall_6th_edge", 32'(bus.sig_out), 32'h3);

    // Flush collides with enable on a full line.
    bus.delay_sel = 4'd2;
    for (int v = 1; v <= 9; v++) begin
      bus.sig_in = 4'(v);
      step();
    end
    check("full_valid", 32'(bus.valid_out), 32'h1);
    bus.flush = 1'b1;
    bus.en = 1'b1;
    bus.sig_in = 4'hF;
    step();
    bus.flush = 1'b0;
    bus.en = 1'b0;
    bus.sig_in = 4'd3;
    for (int s = 1; s <= DEPTH; s++) begin
      bus.delay_sel = 4'(s);
      #1;
      check("flush_tap_out", 32'(bus.sig_out), 32'hA);
      check("flush_tap_valid", 32'(bus.valid_out), 32'h0);
    end
    bus.delay_sel = 4'd0;
    #1;
    check("flush_bypass_out", 32'(bus.sig_out), 32'h3);
    check("flush_bypass_valid", 32'(bus.valid_out), 32'h1);
    step();

    // Clamp and fill saturation over 300 enabled cycles.
    bus.delay_sel = 4'd12;
    bus.en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.sig_in = 4'(i * 3);
      step();
    end
    check("clamp_flag", 32'(bus.sel_clamped), 32'h1);
    check("clamp_out", 32'(bus.sig_out), 32'hC);
    check("clamp_valid", 32'(bus.valid_out), 32'h1);

    // Half-cycle reset pulse while shifting, then full latency on restart.
    bus.delay_sel = 4'd3;
    bus.sig_in = 4'd1;
    step();
    bus.sig_in = 4'd2;
    step();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("pulse_reset_out", 32'(bus.sig_out), 32'hA);
    check("pulse_reset_valid", 32'(bus.valid_out), 32'h0);
    #1;
    sys_rst_n = 1'b1;
    bus.sig_in = 4'd7;
    step();
    bus.sig_in = 4'd8;
    check("restart_valid_1", 32'(bus.valid_out), 32'h0);
    step();
    bus.sig_in = 4'd9;
    check("restart_valid_2", 32'(bus.valid_out), 32'h0);
    step();
    check("restart_out", 32'(bus.sig_out), 32'h7);
    check("restart_valid_3", 32'(bus.valid_out), 32'h1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
